// File: rtl/cam_pkg.sv
// Shared defaults and the priority encoder used by the CAM search and free-slot logic.
// Encoder vectors are sized for the largest supported table (ADDR_WIDTH <= MAX_ADDR_WIDTH).
package cam_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 4;
  localparam int MAX_ADDR_WIDTH = 8;
  localparam int MAX_DEPTH      = 1 << MAX_ADDR_WIDTH;

  typedef struct packed {
    logic                      hit;
    logic                      multi;
    logic [MAX_ADDR_WIDTH-1:0] index;
  } prio_t;

  // Scans from the top so the last assignment leaves the lowest set index.
  function automatic prio_t prio_enc(input logic [MAX_DEPTH-1:0] vec);
    prio_t res;
    res = '0;
    for (int i = MAX_DEPTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        res.multi = res.multi | res.hit;
        res.hit   = 1'b1;
        res.index = i[MAX_ADDR_WIDTH-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/cam_entry.sv
// One CAM row: stored key, valid bit and the combinational compare against the search key.
// With CAM_TERNARY_EN defined, mask bits set to 1 are excluded from the compare.
module cam_entry
  import cam_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  inval_i,
  input  logic                  flush_i,
  input  logic [DATA_WIDTH-1:0] search_data_i,
`ifdef CAM_TERNARY_EN
  input  logic [DATA_WIDTH-1:0] search_mask_i,
`endif
  output logic                  valid_o,
  output logic                  valid_d_o,
  output logic                  match_o
);

  logic [DATA_WIDTH-1:0] key_q;
  logic [DATA_WIDTH-1:0] care;
  logic                  valid_q;
  logic                  valid_d;

  // Flush beats write, write beats invalidate.
  always_comb begin
    valid_d = valid_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (write_i) begin
      valid_d = 1'b1;
    end else if (inval_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (write_i) begin
      key_q <= wdata_i;
    end
  end

`ifdef CAM_TERNARY_EN
  assign care = ~search_mask_i;
`else
  assign care = '1;
`endif

  assign match_o   = valid_q & (((key_q ^ search_data_i) & care) == '0);
  assign valid_o   = valid_q;
  assign valid_d_o = valid_d;

endmodule

// File: rtl/cam_array.sv
// Content-addressable table with a 2-stage search pipeline and a registered free-slot finder.
// Optional macro CAM_TERNARY_EN adds a per-search don't-care mask (search_mask).
module cam_array
  import cam_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  inval_en,
  input  logic [ADDR_WIDTH-1:0] inval_addr,
  input  logic                  flush,
  input  logic                  search_en,
  input  logic [DATA_WIDTH-1:0] search_data,
`ifdef CAM_TERNARY_EN
  input  logic [DATA_WIDTH-1:0] search_mask,
`endif
  output logic                  match_vld,
  output logic                  match_hit,
  output logic [ADDR_WIDTH-1:0] match_addr,
  output logic                  match_multi,
  output logic [ADDR_WIDTH-1:0] free_addr,
  output logic                  full
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DEPTH-1:0]      valid;
  logic [DEPTH-1:0]      valid_d;
  logic [DEPTH-1:0]      match_vec;
  logic [DEPTH-1:0]      s1_vec_q;
  logic                  s1_vld_q;
  logic                  vld_q, hit_q, multi_q, full_q;
  logic [ADDR_WIDTH-1:0] addr_q, free_q;
  logic                  hit_d, multi_d, full_d;
  logic [ADDR_WIDTH-1:0] addr_d, free_d;
  prio_t                 s2_res, free_res;
  logic                  unused_prio;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    cam_entry #(.DATA_WIDTH(DATA_WIDTH)) u_entry (
      .clk          (clk),
      .rst          (rst),
      .write_i      (write_en && (write_addr == ADDR_WIDTH'(gi))),
      .wdata_i      (write_data),
      .inval_i      (inval_en && (inval_addr == ADDR_WIDTH'(gi))),
      .flush_i      (flush),
      .search_data_i(search_data),
`ifdef CAM_TERNARY_EN
      .search_mask_i(search_mask),
`endif
      .valid_o      (valid[gi]),
      .valid_d_o    (valid_d[gi]),
      .match_o      (match_vec[gi])
    );
  end

  // Stage 1 samples the compare against pre-edge table state.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s1_vec_q <= '0;
    end else begin
      s1_vld_q <= search_en;
      s1_vec_q <= search_en ? match_vec : '0;
    end
  end

  always_comb begin
    s2_res   = prio_enc(MAX_DEPTH'(s1_vec_q));
    free_res = prio_enc(MAX_DEPTH'(~valid_d));
    hit_d    = s1_vld_q & s2_res.hit;
    multi_d  = s1_vld_q & s2_res.multi;
    addr_d   = hit_d ? s2_res.index[ADDR_WIDTH-1:0] : '0;
    full_d   = &valid_d;
    // With no invalid entry the encoder reports index 0, which is the required free_addr.
    free_d   = free_res.index[ADDR_WIDTH-1:0];
  end

  assign unused_prio = ^{s2_res, free_res, valid};

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= 1'b0;
      hit_q   <= 1'b0;
      multi_q <= 1'b0;
      addr_q  <= '0;
      free_q  <= '0;
      full_q  <= 1'b0;
    end else begin
      vld_q   <= s1_vld_q;
      hit_q   <= hit_d;
      multi_q <= multi_d;
      addr_q  <= addr_d;
      free_q  <= free_d;
      full_q  <= full_d;
    end
  end

  assign match_vld   = vld_q;
  assign match_hit   = hit_q;
  assign match_addr  = addr_q;
  assign match_multi = multi_q;
  assign free_addr   = free_q;
  assign full        = full_q;

endmodule

// File: tb/tb_cam_array.sv
// Bench for cam_array: directed vector table, hand-written corner sequences and random traffic
// checked every cycle against an array/queue reference model. Define CAM_TERNARY_EN to cover the mask.
module tb_cam_array;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
`ifdef CAM_TERNARY_EN
  localparam bit TERN = 1'b1;
`else
  localparam bit TERN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, write_en, inval_en, flush, search_en;
  logic [AW-1:0] write_addr, inval_addr;
  logic [DW-1:0] write_data, search_data;
`ifdef CAM_TERNARY_EN
  logic [DW-1:0] search_mask;
`endif
  logic          match_vld, match_hit, match_multi, full;
  logic [AW-1:0] match_addr, free_addr;

  always #5 clk = ~clk;

  cam_array #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .write_en   (write_en),
    .write_addr (write_addr),
    .write_data (write_data),
    .inval_en   (inval_en),
    .inval_addr (inval_addr),
    .flush      (flush),
    .search_en  (search_en),
    .search_data(search_data),
`ifdef CAM_TERNARY_EN
    .search_mask(search_mask),
`endif
    .match_vld  (match_vld),
    .match_hit  (match_hit),
    .match_addr (match_addr),
    .match_multi(match_multi),
    .free_addr  (free_addr),
    .full       (full)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          ie;
    logic [AW-1:0] ia;
    logic          fl;
    logic          se;
    logic [DW-1:0] sd;
    logic [DW-1:0] sm;
    logic          rs;
  } stim_t;

  typedef struct {
    stim_t         s;
    logic          ev, eh, em, efull;
    logic [AW-1:0] ea, efree;
  } vec_t;

  typedef struct {
    int            due;
    logic          hit;
    logic [AW-1:0] addr;
    logic          multi;
  } res_t;

  logic [DW-1:0] m_key[DEPTH];
  logic          m_valid[DEPTH];
  res_t          pend[$];
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  vec_t          tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{we: 1'b0, wa: '0, wd: '0, ie: 1'b0, ia: '0, fl: 1'b0, se: 1'b0, sd: '0, sm: '0, rs: 1'b0};
    return s;
  endfunction

  function automatic stim_t wr(input int a, input logic [DW-1:0] d);
    stim_t s;
    s = idle(); s.we = 1'b1; s.wa = AW'(a); s.wd = d;
    return s;
  endfunction

  function automatic stim_t srch(input logic [DW-1:0] d);
    stim_t s;
    s = idle(); s.se = 1'b1; s.sd = d;
    return s;
  endfunction

  function automatic vec_t row(input stim_t s, input logic ev, input logic eh, input int ea,
                               input logic em, input int efree);
    vec_t v;
    v.s = s; v.ev = ev; v.eh = eh; v.ea = AW'(ea); v.em = em; v.efull = 1'b0; v.efree = AW'(efree);
    return v;
  endfunction

  // Reference search: count matching valid entries, remember the first one.
  function automatic res_t model_search(input logic [DW-1:0] sd, input logic [DW-1:0] sm);
    res_t r;
    int   n;
    logic [DW-1:0] care;
    care = TERN ? ~sm : '1;
    r = '{due: 0, hit: 1'b0, addr: '0, multi: 1'b0};
    n = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (m_valid[i] && ((m_key[i] & care) == (sd & care))) begin
        if (n == 0) r.addr = AW'(i);
        n++;
      end
    end
    r.hit   = (n > 0);
    r.multi = (n > 1);
    return r;
  endfunction

  // Apply one cycle of stimulus, advance the model, and check every output.
  task automatic cycle(input stim_t s);
    res_t r, e;
    int   first_free;
    logic all_v;
    write_en = s.we; write_addr = s.wa; write_data = s.wd;
    inval_en = s.ie; inval_addr = s.ia; flush = s.fl;
    search_en = s.se; search_data = s.sd; rst = s.rs;
`ifdef CAM_TERNARY_EN
    search_mask = s.sm;
`endif
    r = model_search(s.sd, s.sm);
    @(posedge clk);
    #1;
    cyc++;
    if (s.rs) begin
      for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
      pend.delete();
    end else begin
      if (s.se) begin
        r.due = cyc + 1;
        pend.push_back(r);
      end
      if (s.fl) begin
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
      end else begin
        if (s.ie) m_valid[s.ia] = 1'b0;
        if (s.we) begin
          m_key[s.wa]   = s.wd;
          m_valid[s.wa] = 1'b1;
        end
      end
    end
    e = '{due: 0, hit: 1'b0, addr: '0, multi: 1'b0};
    if (pend.size() > 0 && pend[0].due == cyc) begin
      e = pend.pop_front();
      chk("m_vld", match_vld, 1);
    end else begin
      chk("m_vld", match_vld, 0);
    end
    chk("m_hit", match_hit, e.hit);
    chk("m_addr", match_addr, e.addr);
    chk("m_multi", match_multi, e.multi);
    first_free = -1;
    all_v = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (!m_valid[i]) begin
        all_v = 1'b0;
        if (first_free < 0) first_free = i;
      end
    end
    if (first_free < 0) first_free = 0;
    chk("m_full", full, all_v);
    chk("m_free", free_addr, first_free);
    $display("cyc %0d: we=%0d wa=%0d ie=%0d fl=%0d se=%0d sd=%0h rst=%0d -> vld=%0d hit=%0d addr=%0d multi=%0d free=%0d full=%0d",
             cyc, s.we, s.wa, s.ie, s.fl, s.se, s.sd, s.rs, match_vld, match_hit, match_addr,
             match_multi, free_addr, full);
  endtask

  initial begin
    stim_t s;
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 1'b0;
      m_key[i]   = '0;
    end

    // Directed table: expected values are observed after that row's clock edge.
    tbl[0]  = row(wr(5, 32'hDEADBEEF), 0, 0, 0, 0, 0);
    tbl[1]  = row(srch(32'hDEADBEEF),  0, 0, 0, 0, 0);
    tbl[2]  = row(idle(),              1, 1, 5, 0, 0);
    tbl[3]  = row(wr(3, 32'h1234),     0, 0, 0, 0, 0);
    tbl[4]  = row(wr(9, 32'h1234),     0, 0, 0, 0, 0);
    tbl[5]  = row(srch(32'h1234),      0, 0, 0, 0, 0);
    s = idle(); s.ie = 1'b1; s.ia = 4'd3;
    tbl[6]  = row(s,                   1, 1, 3, 1, 0);
    tbl[7]  = row(srch(32'h1234),      0, 0, 0, 0, 0);
    tbl[8]  = row(idle(),              1, 1, 9, 0, 0);
    s = wr(0, 32'hAAAA); s.se = 1'b1; s.sd = 32'hAAAA;
    tbl[9]  = row(s,                   0, 0, 0, 0, 1);
    tbl[10] = row(srch(32'hAAAA),      1, 0, 0, 0, 1);
    tbl[11] = row(idle(),              1, 1, 0, 0, 1);
    s = wr(3, 32'h77); s.ie = 1'b1; s.ia = 4'd3;
    tbl[12] = row(s,                   0, 0, 0, 0, 1);
    tbl[13] = row(srch(32'h77),        0, 0, 0, 0, 1);
    tbl[14] = row(idle(),              1, 1, 3, 0, 1);

    s = idle(); s.rs = 1'b1;
    cycle(s);
    cycle(s);
    chk("reset_vld", match_vld, 0);
    chk("reset_free", free_addr, 0);
    chk("reset_full", full, 0);

    for (int i = 0; i < 15; i++) begin
      cycle(tbl[i].s);
      chk($sformatf("row%0d_vld", i), match_vld, tbl[i].ev);
      chk($sformatf("row%0d_hit", i), match_hit, tbl[i].eh);
      chk($sformatf("row%0d_addr", i), match_addr, tbl[i].ea);
      chk($sformatf("row%0d_multi", i), match_multi, tbl[i].em);
      chk($sformatf("row%0d_free", i), free_addr, tbl[i].efree);
      chk($sformatf("row%0d_full", i), full, tbl[i].efull);
    end

    // Fill, then flush with a same-cycle search and an overridden write.
    for (int i = 0; i < DEPTH; i++) cycle(wr(i, 32'h100 + i));
    chk("fill_full", full, 1);
    chk("fill_free", free_addr, 0);
    s = wr(2, 32'h999); s.fl = 1'b1; s.se = 1'b1; s.sd = 32'h105;
    cycle(s);
    chk("flush_full", full, 0);
    chk("flush_free", free_addr, 0);
    cycle(idle());
    chk("flush_srch_vld", match_vld, 1);
    chk("flush_srch_hit", match_hit, 1);
    chk("flush_srch_addr", match_addr, 5);
    cycle(srch(32'h999));
    cycle(idle());
    chk("flush_wr_vld", match_vld, 1);
    chk("flush_wr_hit", match_hit, 0);

    // Reset in the middle of three back-to-back searches: the two in flight are lost.
    cycle(wr(7, 32'h55));
    cycle(srch(32'h55));
    s = srch(32'h55); s.rs = 1'b1;
    cycle(s);
    chk("rst_mid_vld", match_vld, 0);
    chk("rst_mid_hit", match_hit, 0);
    chk("rst_mid_addr", match_addr, 0);
    chk("rst_mid_multi", match_multi, 0);
    chk("rst_mid_free", free_addr, 0);
    chk("rst_mid_full", full, 0);
    cycle(srch(32'h55));
    chk("rst_after_vld", match_vld, 0);
    cycle(idle());
    chk("rst_post_vld", match_vld, 1);
    chk("rst_post_hit", match_hit, 0);

`ifdef CAM_TERNARY_EN
    cycle(wr(0, 32'h00FF));
    s = srch(32'h11FF); s.sm = 32'hFF00;
    cycle(s);
    cycle(idle());
    chk("tern_vld", match_vld, 1);
    chk("tern_hit", match_hit, 1);
    chk("tern_addr", match_addr, 0);
`endif

    // Random traffic over a small key space so hits and multi-hits are frequent.
    for (int n = 0; n < 3000; n++) begin
      s = idle();
      s.we = ($urandom_range(0, 2) == 0);
      s.wa = AW'($urandom_range(0, DEPTH - 1));
      s.wd = ($urandom_range(0, 7) == 0) ? DW'($urandom) : DW'($urandom_range(0, 3));
      s.ie = ($urandom_range(0, 3) == 0);
      s.ia = AW'($urandom_range(0, DEPTH - 1));
      s.fl = ($urandom_range(0, 39) == 0);
      s.se = ($urandom_range(0, 1) == 0);
      s.sd = ($urandom_range(0, 7) == 0) ? DW'($urandom) : DW'($urandom_range(0, 3));
      s.sm = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 3)) : '0;
      s.rs = ($urandom_range(0, 299) == 0);
      cycle(s);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
